psum_accum_writeback: RTL and testbench
=======================================

// Module: psum_accum_writeback
// PURPOSE
//  Downstream of the corelet's MAC array/OFIFO: pops one row (col lanes of psum_bw) per output pixel.
//  Each pass covers one kernel position kij; the block accumulates the row into the output SRAM.
//  kij==0: row is written as-is; kij>0: read-modify-write (signed saturating add).
//  Last kij: applies ReLU before the final write. Pulses done after NPIX rows.
// PARAMETERS
//  col      8   lanes per row (output channels)
//  psum_bw  16  signed psum width per lane
//  NPIX     16  rows (output pixels) per kij pass
//  AW       7   output SRAM address width
//  ADDR_BASE 0  SRAM address of pixel 0
// PORTS
//  clk        in   1            clock, rising edge
//  reset      in   1            asynchronous, active-high
//  start      in   1            begin one kij pass; sampled only in IDLE
//  first_kij  in   1            pass is kij==0 (overwrite); latched at start
//  last_kij   in   1            pass is final kij (apply ReLU); latched at start
//  of_valid   in   1            OFIFO has a row; of_out valid (first-word-fall-through)
//  of_out     in   col*psum_bw  OFIFO head row, lane i at [psum_bw*i +: psum_bw]
//  of_rd      out  1            pop OFIFO head this cycle
//  O_A        out  AW           SRAM address
//  O_CEN      out  1            SRAM chip enable, active-low
//  O_WEN      out  1            SRAM write enable, active-low (1 = read)
//  O_D        out  col*psum_bw  SRAM write data
//  O_Q        in   col*psum_bw  SRAM read data, valid the cycle after a read-enabled edge
//  busy       out  1            high in every state except IDLE
//  done       out  1            one-cycle pulse at end of pass
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, row/sum regs=0; of_rd=0, O_CEN=1, O_WEN=1, O_A=0, O_D=0, busy=0, done=0.
//  All outputs decode from flops only; no combinational path from inputs except of_rd (=of_valid in POP).
//  FSM:
//   IDLE: start -> POP; latch first_kij/last_kij; ptr<=0.
//   POP:  of_valid=0 -> stay (stall). of_valid=1 -> of_rd=1, row<=of_out;
//         next state is WR if first_kij, else RD.
//   RD:   O_CEN=0, O_WEN=1, O_A=ADDR_BASE+ptr -> ADD.
//   ADD:  per lane sum<=sat(row_i+O_Q_i) -> WR.
//   WR:   O_CEN=0, O_WEN=0, O_A=ADDR_BASE+ptr.
//         O_D = (first_kij ? row : sum), each lane ReLU'd (neg->0) if last_kij.
//         If ptr==NPIX-1 -> DONE; else ptr<=ptr+1 -> POP.
//   DONE: done=1 for one cycle -> IDLE.
//  Latency per row after pop: 1 cycle (first_kij) or 3 cycles (accumulate).
//  Arithmetic: signed two's complement; sum clamps to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
//  first_kij and last_kij both set: write ReLU(row) directly.
//  start while busy: ignored. of_valid outside POP: ignored, no pop.
//  Reset mid-pass: immediate return to reset values; partial SRAM contents are left unchanged.
//  ptr never exceeds NPIX-1; no wrap within a pass.
// STRUCTURE
//  Shared package (corelet_pkg): state enum {IDLE,POP,RD,ADD,WR,DONE};
//   sat_add and relu functions parameterised by psum_bw.
//  Sub-module psum_lane_alu, one per lane via generate:
//   sat add + ReLU mux, purely combinational.
//  Top level holds FSM, ptr counter, row/sum registers and SRAM port drive.
// TESTING
//  1. first_kij=1, 16 rows lane i = pix*8+i, of_valid held high
//     -> 16 writes addr 0..15, no reads, 1 pop per 2 cycles, done after row 15.
//  2. Pass 1 writes all lanes 5; pass 2 (kij>0) adds all lanes -3
//     -> each addr reads 5 then writes 2; RD/ADD/WR order checked.
//  3. Saturation: stored 32000 + incoming 1000 -> 32767;
//     stored -32000 + incoming -1000 -> -32768.
//  4. last_kij=1, stored -7 + incoming 2 -> writes 0; stored 3 + incoming 4 -> writes 7.
//  5. of_valid low 5 cycles mid-pass
//     -> FSM holds POP, O_CEN=1, no pop; resumes, ptr unaltered.
//  6. Reset asserted in ADD at ptr=6
//     -> all outputs at reset values that cycle;
//        start then restarts at addr 0; start pulsed while busy is ignored.

Source files
------------

// File: rtl/corelet_pkg.sv
// Purpose: shared types and lane arithmetic for the corelet output path.
// Latency: n/a (types and combinational helper functions only).
// Backpressure: n/a.
package corelet_pkg;

   typedef enum logic [2:0] {
      IDLE,
      POP,
      RD,
      ADD,
      WR,
      DONE
   } state_t;

   // Lane arithmetic is carried out at this width; callers sign-extend their
   // psum_bw-wide lanes into it and truncate the (already clamped) result back.
   localparam int ALU_W = 32;
   localparam logic signed [ALU_W:0] ALU_ONE = {{ALU_W{1'b0}}, 1'b1};

   // Signed add clamped to the representable range of a bw-bit lane.
   function automatic logic signed [ALU_W-1:0] sat_add(
      input logic signed [ALU_W-1:0] a,
      input logic signed [ALU_W-1:0] b,
      input int                      bw
   );
      logic signed [ALU_W:0] s;
      logic signed [ALU_W:0] hi;
      logic signed [ALU_W:0] lo;
      s  = {a[ALU_W-1], a} + {b[ALU_W-1], b};
      hi = (ALU_ONE <<< (bw - 1)) - ALU_ONE;
      lo = -(ALU_ONE <<< (bw - 1));
      if (s > hi) begin
         s = hi;
      end else if (s < lo) begin
         s = lo;
      end
      return s[ALU_W-1:0];
   endfunction

   // Negative values become zero, everything else passes through.
   function automatic logic signed [ALU_W-1:0] relu(
      input logic signed [ALU_W-1:0] a
   );
      return a[ALU_W-1] ? '0 : a;
   endfunction

endpackage

// File: rtl/psum_lane_alu.sv
// Purpose: one output-channel lane: saturating accumulate and write-data select with optional ReLU.
// Latency: purely combinational.
// Backpressure: none; the parent FSM decides when results are captured or written.
module psum_lane_alu
   import corelet_pkg::*;
#(
   parameter int psum_bw = 16
) (
   input  logic [psum_bw-1:0] row,
   input  logic [psum_bw-1:0] q,
   input  logic [psum_bw-1:0] sum,
   input  logic               use_row,
   input  logic               relu_en,
   output logic [psum_bw-1:0] sum_nxt,
   output logic [psum_bw-1:0] wr_dat
);

   logic [psum_bw-1:0] pick;

   assign sum_nxt = psum_bw'(sat_add(ALU_W'($signed(row)), ALU_W'($signed(q)), psum_bw));

   // Overwrite passes write the popped row, accumulate passes the saturated sum; ReLU on the final pass.
   always_comb begin
      pick   = use_row ? row : sum;
      wr_dat = relu_en ? psum_bw'(relu(ALU_W'($signed(pick)))) : pick;
   end

endmodule

// File: rtl/psum_accum_writeback.sv
// Purpose: pops one psum row per output pixel and accumulates it into the output SRAM for one kij pass.
// Latency: 2 cycles per row on an overwrite pass (POP,WR), 4 on accumulate (POP,RD,ADD,WR), plus DONE.
// Backpressure: stalls in POP while of_valid is low; pops only when in POP with of_valid high.
module psum_accum_writeback
   import corelet_pkg::*;
#(
   parameter int col       = 8,
   parameter int psum_bw   = 16,
   parameter int NPIX      = 16,
   parameter int AW        = 7,
   parameter int ADDR_BASE = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   first_kij,
   input  logic                   last_kij,
   input  logic                   of_valid,
   input  logic [col*psum_bw-1:0] of_out,
   output logic                   of_rd,
   output logic [AW-1:0]          O_A,
   output logic                   O_CEN,
   output logic                   O_WEN,
   output logic [col*psum_bw-1:0] O_D,
   input  logic [col*psum_bw-1:0] O_Q,
   output logic                   busy,
   output logic                   done
);

   localparam int RW = col * psum_bw;
   localparam int PW = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(NPIX - 1);

   state_t          state;
   state_t          state_nxt;
   logic [PW-1:0]   ptr;
   logic            first_q;
   logic            last_q;
   logic [RW-1:0]   row_q;
   logic [RW-1:0]   sum_q;
   logic [RW-1:0]   sum_nxt;
   logic [RW-1:0]   wr_dat;

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; of_rd is the only output allowed to follow an input directly.
   always_comb begin
      state_nxt = state;
      of_rd     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = POP;
            end
         end
         POP: begin
            if (of_valid) begin
               of_rd     = 1'b1;
               state_nxt = first_q ? WR : RD;
            end
         end
         RD:   state_nxt = ADD;
         ADD:  state_nxt = WR;
         WR:   state_nxt = (ptr == PTR_LAST) ? DONE : POP;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Pass flags, pixel pointer and the row/sum holding registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr     <= '0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         row_q   <= '0;
         sum_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  first_q <= first_kij;
                  last_q  <= last_kij;
                  ptr     <= '0;
               end
            end
            POP: begin
               if (of_valid) begin
                  row_q <= of_out;
               end
            end
            ADD: sum_q <= sum_nxt;
            WR: begin
               if (ptr != PTR_LAST) begin
                  ptr <= ptr + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar i = 0; i < col; i++) begin : g_lane
      psum_lane_alu #(
         .psum_bw (psum_bw)
      ) u_alu (
         .row     (row_q[psum_bw*i +: psum_bw]),
         .q       (O_Q[psum_bw*i +: psum_bw]),
         .sum     (sum_q[psum_bw*i +: psum_bw]),
         .use_row (first_q),
         .relu_en (last_q),
         .sum_nxt (sum_nxt[psum_bw*i +: psum_bw]),
         .wr_dat  (wr_dat[psum_bw*i +: psum_bw])
      );
   end

   // SRAM port and status drive, decoded from registered state only.
   assign O_CEN = !((state == RD) || (state == WR));
   assign O_WEN = !(state == WR);
   assign O_A   = ((state == RD) || (state == WR)) ? (AW'(ADDR_BASE) + AW'(ptr)) : '0;
   assign O_D   = (state == WR) ? wr_dat : '0;
   assign busy  = (state != IDLE);
   assign done  = (state == DONE);

endmodule

// File: tb/tb_psum_accum_writeback.sv
// Purpose: randomized bench for psum_accum_writeback with OFIFO/SRAM models and a per-pixel reference.
// Latency: checks per-row cycle spacing and total pass length against the row schedule.
// Backpressure: injects of_valid stalls mid-pass and checks the block holds without popping.
module tb_psum_accum_writeback;

   localparam int COL    = 8;
   localparam int BW     = 16;
   localparam int NPIX   = 16;
   localparam int AW     = 7;
   localparam int BASE   = 0;
   localparam int RW     = COL * BW;
   localparam int BUDGET = 2000;
   localparam int PMAX   = (1 << (BW - 1)) - 1;
   localparam int PMIN   = -(1 << (BW - 1));

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          first_kij;
   logic          last_kij;
   logic          of_valid = 1'b0;
   logic [RW-1:0] of_out = '0;
   logic          of_rd;
   logic [AW-1:0] O_A;
   logic          O_CEN;
   logic          O_WEN;
   logic [RW-1:0] O_D;
   logic [RW-1:0] O_Q = '0;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   psum_accum_writeback #(
      .col       (COL),
      .psum_bw   (BW),
      .NPIX      (NPIX),
      .AW        (AW),
      .ADDR_BASE (BASE)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .first_kij (first_kij),
      .last_kij  (last_kij),
      .of_valid  (of_valid),
      .of_out    (of_out),
      .of_rd     (of_rd),
      .O_A       (O_A),
      .O_CEN     (O_CEN),
      .O_WEN     (O_WEN),
      .O_D       (O_D),
      .O_Q       (O_Q),
      .busy      (busy),
      .done      (done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   logic [RW-1:0] sram    [0:(1<<AW)-1];
   logic [RW-1:0] ref_mem [0:NPIX-1];
   logic [RW-1:0] exp_row [0:NPIX-1];
   logic [RW-1:0] rows    [0:NPIX-1];
   logic [RW-1:0] fifo_q  [$];

   int            cyc = 0, pop_cnt = 0, rd_cnt = 0, wr_idx = 0;
   int            last_pop_cyc = 0, last_rd_cyc = 0, done_cyc = 0;
   logic [AW-1:0] last_rd_addr = '0;
   bit            cur_first = 1'b0, done_seen = 1'b0, do_pop = 1'b0;
   int            stall_at = -1, stall_rem = 0;
   logic          cap_cen = 1'b1, cap_wen = 1'b1;
   logic [AW-1:0] cap_a = '0;
   logic [RW-1:0] cap_d = '0;

   // Observe the DUT mid-cycle: protocol checks, write scoreboard, SRAM/FIFO requests for the next edge.
   always @(negedge clk) begin
      do_pop  = 1'b0;
      cap_cen = 1'b1;
      if (!reset) begin
         cyc++;
         if (start && !busy) begin
            cyc = 0; pop_cnt = 0; rd_cnt = 0; wr_idx = 0;
            done_seen = 1'b0; cur_first = first_kij;
         end else if (busy) begin
            if (!of_valid) check("pop_without_valid", of_rd, 0);
            if (stall_rem >= 1 && stall_rem <= 5) check("stall_cen", O_CEN, 1);
            if (of_rd) begin
               if (pop_cnt == 0) check("first_pop_cycle", cyc, 1);
               else check("pop_gap", cyc - last_pop_cyc,
                          (cur_first ? 2 : 4) + ((pop_cnt == stall_at) ? 5 : 0));
               last_pop_cyc = cyc;
               pop_cnt++;
               do_pop = 1'b1;
            end
            if (!O_CEN && O_WEN) begin
               check("read_in_overwrite", cur_first, 0);
               check("rd_addr", O_A, BASE + rd_cnt);
               last_rd_addr = O_A;
               last_rd_cyc  = cyc;
               rd_cnt++;
            end
            if (!O_CEN && !O_WEN) begin
               if (wr_idx < NPIX) begin
                  check("wr_addr", O_A, BASE + wr_idx);
                  check("wr_data", O_D, exp_row[wr_idx]);
                  if (!cur_first) begin
                     check("rmw_gap", cyc - last_rd_cyc, 2);
                     check("rmw_addr", last_rd_addr, O_A);
                  end
               end else begin
                  check("wr_overrun", wr_idx, NPIX - 1);
               end
               wr_idx++;
            end
            if (done) begin
               check("done_after_all_wr", wr_idx, NPIX);
               done_seen = 1'b1;
               done_cyc  = cyc;
            end
            cap_cen = O_CEN; cap_wen = O_WEN; cap_a = O_A; cap_d = O_D;
         end
      end
   end

   // OFIFO (first-word-fall-through) and SRAM (registered read) models, updated just after the edge.
   always @(posedge clk) begin
      #1;
      if (do_pop) begin
         if (fifo_q.size() > 0) fifo_q.delete(0);
         if (pop_cnt == stall_at) stall_rem = 5 + (cur_first ? 1 : 3);
      end else if (stall_rem > 0) begin
         stall_rem--;
      end
      if (!cap_cen) begin
         if (!cap_wen) sram[cap_a] = cap_d;
         else          O_Q = sram[cap_a];
      end
      of_valid = (stall_rem == 0) && (fifo_q.size() > 0);
      of_out   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
   end

   function automatic int sx(input logic [BW-1:0] v);
      logic signed [BW-1:0] t;
      t = v;
      return int'(t);
   endfunction

   function automatic int clamp(input int v);
      if (v > PMAX) return PMAX;
      if (v < PMIN) return PMIN;
      return v;
   endfunction

   // Reference: per pixel and lane, overwrite or saturating add, then ReLU on the last kij.
   task automatic build_expect(input bit first, input bit last);
      for (int p = 0; p < NPIX; p++) begin
         for (int i = 0; i < COL; i++) begin
            int r, m, v;
            r = sx(rows[p][BW*i +: BW]);
            m = sx(ref_mem[p][BW*i +: BW]);
            v = first ? r : clamp(r + m);
            if (last && v < 0) v = 0;
            exp_row[p][BW*i +: BW] = BW'(v);
         end
      end
   endtask

   task automatic set_lane(input int p, input int i, input int v);
      rows[p][BW*i +: BW] = BW'(v);
   endtask

   task automatic fill_rand(input int p);
      for (int i = 0; i < COL; i++) set_lane(p, i, int'($urandom_range(0, 65535)) - 32768);
   endtask

   task automatic start_pass(input bit first, input bit last, input int stall);
      build_expect(first, last);
      @(posedge clk); #2;
      for (int p = 0; p < NPIX; p++) fifo_q.push_back(rows[p]);
      stall_at  = stall;
      first_kij = first;
      last_kij  = last;
      start     = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   task automatic check_mem();
      for (int p = 0; p < NPIX; p++) check("sram_contents", sram[BASE + p], ref_mem[p]);
   endtask

   task automatic wait_done(input bit first, input int stall);
      for (int k = 0; k < BUDGET && !done_seen; k++) @(posedge clk);
      check("done_seen", done_seen, 1);
      check("pass_cycles", done_cyc, 1 + NPIX * (first ? 2 : 4) + ((stall >= 0) ? 5 : 0));
      check("pop_count", pop_cnt, NPIX);
      check("read_count", rd_cnt, first ? 0 : NPIX);
      check("write_count", wr_idx, NPIX);
      @(negedge clk); #1;
      check("done_one_cycle", done, 0);
      check("idle_after_done", busy, 0);
      for (int p = 0; p < NPIX; p++) ref_mem[p] = exp_row[p];
      check_mem();
   endtask

   task automatic run_pass(input bit first, input bit last, input int stall);
      start_pass(first, last, stall);
      wait_done(first, stall);
   endtask

   task automatic check_reset_outs();
      check("rst_of_rd", of_rd, 0);
      check("rst_cen", O_CEN, 1);
      check("rst_wen", O_WEN, 1);
      check("rst_addr", O_A, 0);
      check("rst_d", O_D, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; start = 1'b0; first_kij = 1'b0; last_kij = 1'b0;
      for (int a = 0; a < (1 << AW); a++) sram[a] = '0;
      for (int p = 0; p < NPIX; p++) ref_mem[p] = '0;
      repeat (2) @(posedge clk); #2;
      check_reset_outs();
      reset = 1'b0;

      // Overwrite pass, lane i of pixel p = p*8+i, FIFO always ready.
      for (int p = 0; p < NPIX; p++) for (int i = 0; i < COL; i++) set_lane(p, i, p * 8 + i);
      run_pass(1'b1, 1'b0, -1);

      // 5 written, then -3 accumulated.
      for (int p = 0; p < NPIX; p++) for (int i = 0; i < COL; i++) set_lane(p, i, 5);
      run_pass(1'b1, 1'b0, -1);
      for (int p = 0; p < NPIX; p++) for (int i = 0; i < COL; i++) set_lane(p, i, -3);
      run_pass(1'b0, 1'b0, -1);

      // Saturation at both rails on the first 8 pixels, random elsewhere.
      for (int p = 0; p < NPIX; p++) begin
         fill_rand(p);
         if (p < 8) for (int i = 0; i < COL; i++) set_lane(p, i, (i % 2 == 0) ? 32000 : -32000);
      end
      run_pass(1'b1, 1'b0, -1);
      for (int p = 0; p < NPIX; p++) begin
         fill_rand(p);
         if (p < 8) for (int i = 0; i < COL; i++) set_lane(p, i, (i % 2 == 0) ? 1000 : -1000);
      end
      run_pass(1'b0, 1'b0, -1);

      // Final kij with ReLU: -7+2 -> 0, 3+4 -> 7.
      for (int p = 0; p < NPIX; p++) begin
         fill_rand(p);
         if (p < 2) for (int i = 0; i < COL; i++) set_lane(p, i, (p == 0) ? -7 : 3);
      end
      run_pass(1'b1, 1'b0, -1);
      for (int p = 0; p < NPIX; p++) begin
         fill_rand(p);
         if (p < 2) for (int i = 0; i < COL; i++) set_lane(p, i, (p == 0) ? 2 : 4);
      end
      run_pass(1'b0, 1'b1, -1);

      // of_valid stalls mid-pass on both pass kinds.
      for (int p = 0; p < NPIX; p++) fill_rand(p);
      run_pass(1'b0, 1'b0, 7);
      for (int p = 0; p < NPIX; p++) fill_rand(p);
      run_pass(1'b1, 1'b0, 3);

      // first_kij and last_kij together: ReLU(row) written directly.
      for (int p = 0; p < NPIX; p++) fill_rand(p);
      run_pass(1'b1, 1'b1, -1);

      // Reset while in ADD for pixel 6.
      for (int p = 0; p < NPIX; p++) fill_rand(p);
      start_pass(1'b0, 1'b0, -1);
      for (int k = 0; k < BUDGET && rd_cnt < 7; k++) @(posedge clk);
      check("abort_reads", rd_cnt, 7);
      #2;
      reset = 1'b1;
      #1;
      check_reset_outs();
      check("abort_writes", wr_idx, 6);
      @(posedge clk); #2;
      fifo_q.delete();
      stall_at = -1;
      @(posedge clk); #2;
      reset = 1'b0;
      for (int p = 0; p < 6; p++) ref_mem[p] = exp_row[p];
      check_mem();

      // Restart from pixel 0; a start pulse mid-pass must not disturb it.
      for (int p = 0; p < NPIX; p++) fill_rand(p);
      start_pass(1'b0, 1'b0, -1);
      repeat (10) @(posedge clk);
      #2;
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      wait_done(1'b0, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
